data_memory_bank: RTL and testbench

- Parametrised word-addressed data memory for the ARMv4 core's load/store stage.
- Generalises the current single-port data memory: configurable width and depth, byte-lane writes, two independent synchronous read ports (A: core load path, B: debug/video readout), all activity on the rising clock edge.
- Post-reset hardware clear sequence.
- Alignment and range error reporting.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_clear_ctrl.sv | 41 ++++
 rtl/data_memory_bank.sv | 132 +++++++++++++
 tb/tb_data_memory_bank.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the parametrised data memory bank.
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_DEPTH  = 4096;
  localparam int DMEM_ADDR_W = 32;

  typedef enum logic [0:0] {
    DMEM_CLEAR = 1'b0,
    DMEM_READY = 1'b1
  } dmem_state_e;

  // One byte lane of a partial write: new byte where enabled, old byte otherwise.
  function automatic logic [7:0] dmem_lane_merge(input logic [7:0] old_b,
                                                 input logic [7:0] new_b,
                                                 input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/dmem_clear_ctrl.sv
// Post-reset clear sequencer: zeroes every word once, then reports init_done.
module dmem_clear_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             clr_en_o,
  output logic [IDX_W-1:0] clr_idx_o,
  output logic             init_done_o
);

  dmem_state_e      state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == DMEM_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IDX_W'(DEPTH - 1)) state_d = DMEM_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DMEM_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clr_en_o    = (state_q == DMEM_CLEAR);
  assign clr_idx_o   = cnt_q;
  assign init_done_o = (state_q == DMEM_READY);

endmodule

// File: rtl/data_memory_bank.sv
// Word-addressed data memory: byte-lane writes, two synchronous read ports, post-reset clear.
// Define DMEM_WR_FORWARD_EN to forward a same-cycle write into port A reads.
module data_memory_bank
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en_a,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic                rd_valid_a,
  input  logic                rd_en_b,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                rd_valid_b,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                init_done,
  output logic                misalign_err,
  output logic                range_err
);

  localparam int LANES = DATA_W / 8;
  localparam int OFFS  = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);

  // Any set address bit above the word index means the word is past the end.
  function automatic logic is_oor(input logic [ADDR_W-1:0] addr);
    logic r;
    r = 1'b0;
    for (int i = OFFS + IDX_W; i < ADDR_W; i++) r = r | addr[i];
    return r;
  endfunction

  function automatic logic is_mis(input logic [ADDR_W-1:0] addr);
    logic r;
    r = 1'b0;
    for (int i = 0; i < OFFS; i++) r = r | addr[i];
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr[OFFS +: IDX_W];
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              clr_en;
  logic [IDX_W-1:0]  clr_idx;
  logic              ready;

  dmem_clear_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_clear (
    .clk         (clk),
    .rst         (rst),
    .clr_en_o    (clr_en),
    .clr_idx_o   (clr_idx),
    .init_done_o (ready)
  );

  logic              acc_a, acc_b, acc_w, wr_ok;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_word;

  assign acc_a  = ready & rd_en_a;
  assign acc_b  = ready & rd_en_b;
  assign acc_w  = ready & wr_en;
  assign wr_idx = word_idx(wr_addr);
  assign wr_ok  = acc_w & ~is_oor(wr_addr);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign wr_word[8*l +: 8] = dmem_lane_merge(mem_q[wr_idx][8*l +: 8],
                                               wr_data[8*l +: 8], wr_be[l]);
  end

  always_ff @(posedge clk) begin
    if (clr_en) mem_q[clr_idx] <= '0;
    else if (wr_ok) mem_q[wr_idx] <= wr_word;
  end

  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
  logic              rd_valid_a_q, rd_valid_b_q, mis_q, mis_d, rng_q, rng_d;

  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (acc_a) begin
      rd_data_a_d = is_oor(rd_addr_a) ? '0 : mem_q[word_idx(rd_addr_a)];
`ifdef DMEM_WR_FORWARD_EN
      if (wr_ok && !is_oor(rd_addr_a) && (wr_idx == word_idx(rd_addr_a)))
        rd_data_a_d = wr_word;
`endif
    end
    // Port B never forwards: it always sees the word as it stood before this edge.
    if (acc_b) rd_data_b_d = is_oor(rd_addr_b) ? '0 : mem_q[word_idx(rd_addr_b)];
    mis_d = (acc_a & is_mis(rd_addr_a)) | (acc_b & is_mis(rd_addr_b)) |
            (acc_w & is_mis(wr_addr));
    rng_d = (acc_a & is_oor(rd_addr_a)) | (acc_b & is_oor(rd_addr_b)) |
            (acc_w & is_oor(wr_addr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      mis_q        <= 1'b0;
      rng_q        <= 1'b0;
    end else begin
      rd_data_a_q  <= rd_data_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_a_q <= acc_a;
      rd_valid_b_q <= acc_b;
      mis_q        <= mis_d;
      rng_q        <= rng_d;
    end
  end

  assign rd_data_a    = rd_data_a_q;
  assign rd_data_b    = rd_data_b_q;
  assign rd_valid_a   = rd_valid_a_q;
  assign rd_valid_b   = rd_valid_b_q;
  assign misalign_err = mis_q;
  assign range_err    = rng_q;
  assign init_done    = ready;

endmodule

// File: tb/tb_data_memory_bank.sv
// Scoreboard bench for data_memory_bank (DEPTH=16, 32-bit words) with a behavioural memory model.
module tb_data_memory_bank;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en_a = 1'b0, rd_en_b = 1'b0, wr_en = 1'b0;
  logic [31:0] rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0, wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, init_done, misalign_err, range_err;

  always #5 clk = ~clk;

  data_memory_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .init_done(init_done), .misalign_err(misalign_err), .range_err(range_err)
  );

  typedef struct packed {
    logic        va;
    logic [31:0] da;
    logic        vb;
    logic [31:0] db;
    logic        mis;
    logic        rng;
    logic        init;
  } exp_t;

  exp_t        sbq[$];
  exp_t        me;
  int          checks = 0;
  int          errors = 0;

  // Reference model: plain word array, cycle count since reset release, last returned data.
  logic [31:0] mdl_mem [DEPTH];
  int          post_rst = 0;
  logic [31:0] last_a = '0, last_b = '0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp_v, $time);
    end
  endtask

  task automatic step(input logic r, input logic ea, input logic [31:0] aa,
                      input logic eb, input logic [31:0] ab,
                      input logic we, input logic [31:0] wa,
                      input logic [3:0] be, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] mask, merged, ia, ib, wi;
    logic        wr_in;
    @(negedge clk);
    rst = r; rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    e = '0;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
      post_rst = 0; last_a = '0; last_b = '0;
    end else begin
      if (post_rst >= DEPTH) begin
        wi    = wa >> 2;
        wr_in = (wi < DEPTH);
        mask  = 32'h0;
        for (int l = 0; l < 4; l++) if (be[l]) mask = mask | (32'hFF << (8 * l));
        merged = wr_in ? ((mdl_mem[wi[3:0]] & ~mask) | (wd & mask)) : 32'h0;
        if (ea) begin
          ia = aa >> 2;
          e.va = 1'b1;
          last_a = (ia < DEPTH) ? mdl_mem[ia[3:0]] : 32'h0;
`ifdef DMEM_WR_FORWARD_EN
          if (we && wr_in && ia == wi) last_a = merged;
`endif
          e.mis = e.mis | (aa[1:0] != 2'b00);
          e.rng = e.rng | (ia >= DEPTH);
        end
        if (eb) begin
          ib = ab >> 2;
          e.vb = 1'b1;
          last_b = (ib < DEPTH) ? mdl_mem[ib[3:0]] : 32'h0;
          e.mis = e.mis | (ab[1:0] != 2'b00);
          e.rng = e.rng | (ib >= DEPTH);
        end
        if (we) begin
          e.mis = e.mis | (wa[1:0] != 2'b00);
          e.rng = e.rng | !wr_in;
          if (wr_in) mdl_mem[wi[3:0]] = merged;
        end
      end
      post_rst++;
      e.init = (post_rst >= DEPTH);
    end
    e.da = last_a;
    e.db = last_b;
    sbq.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic rd_a(input logic [31:0] a);
    step(1'b0, 1'b1, a, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, a, be, d);
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      chk("rd_valid_a", {31'b0, rd_valid_a}, {31'b0, me.va});
      chk("rd_data_a", rd_data_a, me.da);
      chk("rd_valid_b", {31'b0, rd_valid_b}, {31'b0, me.vb});
      chk("rd_data_b", rd_data_b, me.db);
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, me.mis});
      chk("range_err", {31'b0, range_err}, {31'b0, me.rng});
      chk("init_done", {31'b0, init_done}, {31'b0, me.init});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (DEPTH) idle();
    for (int i = 0; i < DEPTH; i++) rd_a(32'(i * 4));

    wr(32'h10, 4'hF, 32'hAABBCCDD);
    wr(32'h10, 4'b0101, 32'h11223344);
    rd_a(32'h10);

    wr(32'h0C, 4'hF, 32'h12345678);
    wr(32'h14, 4'hF, 32'hCAFEF00D);
    step(1'b0, 1'b1, 32'h0C, 1'b1, 32'h14, 1'b0, 32'h0, 4'h0, 32'h0);

    wr(32'h08, 4'hF, 32'h0);
    step(1'b0, 1'b1, 32'h08, 1'b1, 32'h08, 1'b1, 32'h08, 4'h3, 32'hFFFFFFFF);
    step(1'b0, 1'b1, 32'h08, 1'b1, 32'h08, 1'b0, 32'h0, 4'h0, 32'h0);

    wr(32'h00, 4'hF, 32'h600DF00D);
    rd_a(32'h42);
    wr(32'h40, 4'hF, 32'hDEADBEEF);
    step(1'b0, 1'b1, 32'h00, 1'b1, 32'h05, 1'b0, 32'h0, 4'h0, 32'h0);
    wr(32'h14, 4'h0, 32'h0BAD0BAD);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h14, 1'b0, 32'h0, 4'h0, 32'h0);

    wr(32'h04, 4'hF, 32'h55);
    step(1'b1, 1'b1, 32'h04, 1'b1, 32'h04, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) rd_a(32'h04);
    repeat (DEPTH - 3) idle();
    rd_a(32'h04);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 1)), 32'($urandom_range(0, 'h47)),
           1'($urandom_range(0, 1)), 32'($urandom_range(0, 'h47)),
           1'($urandom_range(0, 1)), 32'($urandom_range(0, 'h47)),
           4'($urandom_range(0, 15)), $urandom());
    end

    repeat (2) idle();
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
